// File: rtl/accel_wrapper.sv
// Scratch-memory accelerator: host loads MEM_DEPTH words, a start edge folds them into sum/xor written to words 0/1.
// Latency: done pulses MEM_DEPTH+2 cycles after the trigger edge; host accesses during RUN/WRITE are dropped and flagged.
package accel_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WRITE = 2'd2, DONE = 2'd3} acc_state_t;
  typedef enum logic [1:0] {NO_ERR = 2'd0, ADDR_RANGE = 2'd1, BUSY_ACCESS = 2'd2} acc_error_t;
endpackage

module accel_wrapper
  import accel_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int MEM_DEPTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output acc_state_t                  accel_state,
  output acc_error_t                  accel_error,
  input  logic                        start,
  output logic                        done,
  output logic [5:0]                  output_length_byte,
  input  logic                        mem_en,
  input  logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
  input  logic                        mem_we,
  input  logic [MEM_DATA_WIDTH/8-1:0] mem_be,
  input  logic [MEM_DATA_WIDTH-1:0]   mem_wdata,
  output logic [MEM_DATA_WIDTH-1:0]   mem_rdata
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  acc_state_t                state_q, state_d;
  acc_error_t                err_q, err_d;
  logic                      start_q, start_d;
  logic                      done_q, done_d;
  logic [5:0]                len_q, len_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [MEM_DATA_WIDTH-1:0] sum_q, sum_d;
  logic [MEM_DATA_WIDTH-1:0] xor_q, xor_d;
  logic [MEM_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [MEM_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [MEM_DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

  logic             host_ok;
  logic             in_range;
  logic             trig;
  logic [IDX_W-1:0] host_idx;

  assign host_ok  = (state_q == IDLE) || (state_q == DONE);
  assign in_range = mem_addr < MEM_ADDR_WIDTH'(MEM_DEPTH);
  assign trig     = start & ~start_q;
  assign host_idx = mem_addr[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    start_d = start;
    done_d  = 1'b0;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    xor_d   = xor_q;
    rdata_d = rdata_q;
    mem_d   = mem_q;

    // Busy takes precedence over range so a RUN-time access always reports BUSY_ACCESS.
    if (mem_en) begin
      if (!host_ok) begin
        err_d = BUSY_ACCESS;
        if (!mem_we) rdata_d = '0;
      end else if (!in_range) begin
        err_d = ADDR_RANGE;
        if (!mem_we) rdata_d = '0;
      end else if (mem_we) begin
        for (int k = 0; k < MEM_DATA_WIDTH/8; k++) begin
          if (mem_be[k]) mem_d[host_idx][8*k +: 8] = mem_wdata[8*k +: 8];
        end
      end else begin
        rdata_d = mem_q[host_idx];
      end
    end

    // A same-cycle host write lands in mem_q before RUN reads index 0, so it is seen.
    case (state_q)
      IDLE, DONE: begin
        if (trig) begin
          state_d = RUN;
          idx_d   = '0;
          sum_d   = '0;
          xor_d   = '0;
          err_d   = NO_ERR;
          len_d   = '0;
        end
      end
      RUN: begin
        sum_d = sum_q + mem_q[idx_q];
        xor_d = xor_q ^ mem_q[idx_q];
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(MEM_DEPTH - 1)) state_d = WRITE;
      end
      WRITE: begin
        mem_d[0] = sum_q;
        mem_d[1] = xor_q;
        len_d    = 6'd8;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      err_q   <= NO_ERR;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      xor_q   <= '0;
      rdata_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      start_q <= start_d;
      done_q  <= done_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      xor_q   <= xor_d;
      rdata_q <= rdata_d;
      mem_q   <= mem_d;
    end
  end

  assign accel_state        = state_q;
  assign accel_error        = err_q;
  assign done               = done_q;
  assign output_length_byte = len_q;
  assign mem_rdata          = rdata_q;
endmodule

// File: tb/tb_accel_wrapper.sv
// Randomized bench for accel_wrapper against a word-array reference model of the scratch memory.
module tb_accel_wrapper;
  localparam int DEPTH = 16;
  localparam logic [31:0] ST_IDLE = 0, ST_RUN = 1, ST_WRITE = 2, ST_DONE = 3;
  localparam logic [31:0] E_NONE = 0, E_RANGE = 1, E_BUSY = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  accel_pkg::acc_state_t accel_state;
  accel_pkg::acc_error_t accel_error;
  logic                 start = 1'b0;
  logic                 done;
  logic [5:0]           output_length_byte;
  logic                 mem_en = 1'b0;
  logic [31:0]          mem_addr = '0;
  logic                 mem_we = 1'b0;
  logic [3:0]           mem_be = '0;
  logic [31:0]          mem_wdata = '0;
  logic [31:0]          mem_rdata;

  accel_wrapper #(.MEM_ADDR_WIDTH(32), .MEM_DATA_WIDTH(32), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .accel_state(accel_state), .accel_error(accel_error),
    .start(start), .done(done), .output_length_byte(output_length_byte),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    mem_en = 1'b1; mem_we = 1'b1; mem_addr = a; mem_wdata = d; mem_be = be;
    tick();
    mem_en = 1'b0; mem_we = 1'b0;
    if (a < DEPTH) begin
      for (int k = 0; k < 4; k++) if (be[k]) model_mem[a][8*k +: 8] = d[8*k +: 8];
    end else begin
      model_err = E_RANGE;
    end
  endtask

  task automatic host_read(input string tag, input logic [31:0] a);
    mem_en = 1'b1; mem_we = 1'b0; mem_addr = a;
    tick();
    mem_en = 1'b0;
    if (a >= DEPTH) model_err = E_RANGE;
    chk(tag, mem_rdata, (a < DEPTH) ? model_mem[a] : 32'h0);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++) host_read(tag, 32'(i));
  endtask

  // Runs one job; observation t is taken just after the t-th edge following the trigger edge.
  task automatic run_job(input string tag, input bit hold, input bit busy_poke);
    logic [31:0] s, x;
    int run_n, wr_n, done_n, done_at;
    s = 0; x = 0;
    for (int i = 0; i < DEPTH; i++) begin
      s = s + model_mem[i];
      x = x ^ model_mem[i];
    end
    run_n = 0; wr_n = 0; done_n = 0; done_at = -1;
    start = 1'b1;
    tick();
    model_err = E_NONE;
    chk({tag, "_err_clr"}, 32'(accel_error), E_NONE);
    for (int t = 0; t < 26; t++) begin
      if (32'(accel_state) == ST_RUN) run_n++;
      if (32'(accel_state) == ST_WRITE) wr_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = t;
      end
      if (!hold && t == 0) start = 1'b0;
      if (busy_poke) begin
        if (t == 3) begin mem_en = 1'b1; mem_we = 1'b0; mem_addr = 32'd2; end
        if (t == 4) begin
          mem_en = 1'b0;
          model_err = E_BUSY;
          chk({tag, "_busy_rdata"}, mem_rdata, 32'h0);
          chk({tag, "_busy_err"}, 32'(accel_error), E_BUSY);
        end
        if (t == 5) start = 1'b0;
        if (t == 6) start = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    tick();
    model_mem[0] = s;
    model_mem[1] = x;
    chk({tag, "_run_cycles"}, 32'(run_n), DEPTH);
    chk({tag, "_write_cycles"}, 32'(wr_n), 1);
    chk({tag, "_done_pulses"}, 32'(done_n), 1);
    // done visible after edge T+17, i.e. in the cycle ending at edge T+DEPTH+2
    chk({tag, "_done_latency"}, 32'(done_at + 1), DEPTH + 2);
    chk({tag, "_state_done"}, 32'(accel_state), ST_DONE);
    chk({tag, "_out_len"}, 32'(output_length_byte), 8);
    chk({tag, "_err"}, 32'(accel_error), model_err);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    model_err = E_NONE;
    repeat (3) tick();
    rst_n = 1'b0;
    chk("rst_state", 32'(accel_state), ST_IDLE);
    chk("rst_done", 32'(done), 0);
    chk("rst_len", 32'(output_length_byte), 0);
    chk("rst_err", 32'(accel_error), E_NONE);
    chk("rst_rdata", mem_rdata, 32'h0);
    read_all("rst_mem");

    // Directed job: out-of-range writes must not alias into the buffer
    host_write(32'd0, 32'h5555_5555, 4'hF);
    host_write(32'd1, 32'h8000_0000, 4'hF);
    for (int i = 2; i < DEPTH; i++) host_write(32'(i), 32'h0, 4'hF);
    for (int a = DEPTH; a <= 42; a++) host_write(32'(a), (a == 41) ? 32'h1 : 32'h0, 4'hF);
    chk("range_err", 32'(accel_error), E_RANGE);
    run_job("dir", 1'b1, 1'b0);
    host_read("dir_w0", 32'd0);
    chk("dir_w0_const", mem_rdata, 32'hD555_5555);
    host_read("dir_w1", 32'd1);
    chk("dir_w1_const", mem_rdata, 32'hD555_5555);
    read_all("dir_mem");

    host_write(32'd3, 32'hFFFF_FFFF, 4'hF);
    host_write(32'd3, 32'h0000_0000, 4'b0101);
    host_read("be_read", 32'd3);
    chk("be_const", mem_rdata, 32'hFF00_FF00);

    for (int i = 0; i < DEPTH; i++) host_write(32'(i), $urandom, 4'hF);
    run_job("busy", 1'b1, 1'b1);
    read_all("busy_mem");

    for (int i = 0; i < DEPTH; i++) host_write(32'(i), 32'hFFFF_FFFF, 4'hF);
    run_job("ones", 1'b0, 1'b0);
    host_read("ones_w0", 32'd0);
    chk("ones_w0_const", mem_rdata, 32'hFFFF_FFF0);
    host_read("ones_w1", 32'd1);
    chk("ones_w1_const", mem_rdata, 32'h0);

    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < DEPTH; i++) host_write(32'(i), $urandom, 4'hF);
      for (int j = 0; j < 8; j++) begin
        host_write(32'($urandom_range(0, 20)), $urandom, 4'($urandom_range(0, 15)));
        host_read("rnd_read", 32'($urandom_range(0, 20)));
      end
      chk("rnd_err", 32'(accel_error), model_err);
      run_job("rnd", it[0], 1'b0);
      read_all("rnd_mem");
    end

    // Mid-run reset aborts with cleared memory and no done pulse
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("mid_state_run", 32'(accel_state), ST_RUN);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    model_err = E_NONE;
    chk("mid_rst_state", 32'(accel_state), ST_IDLE);
    chk("mid_rst_err", 32'(accel_error), E_NONE);
    chk("mid_rst_len", 32'(output_length_byte), 0);
    begin
      int late_done = 0;
      for (int t = 0; t < 24; t++) begin
        if (done) late_done++;
        tick();
      end
      chk("mid_rst_no_done", 32'(late_done), 0);
    end
    chk("mid_rst_idle", 32'(accel_state), ST_IDLE);
    read_all("mid_rst_mem");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/accel_wrapper.md
Name: accel_wrapper

Overview:
- Template hardware accelerator with a host-visible word-addressed scratch memory of MEM_DEPTH words.
- The host (PULPino-side bus adapter) loads input words, pulses start, and waits for done.
- On done, it reads the results back from the same memory.
- The accelerator computes a wrapping 32-bit sum and an XOR fold over the whole buffer and writes them to words 0 and 1.

Parameters:
- MEM_ADDR_WIDTH, 32: width of mem_addr (word address).
- MEM_DATA_WIDTH, 32: memory word width. Only 32 is supported; sum wraps mod 2^32.
- MEM_DEPTH, 16: number of words in the buffer (16 x 32 = 512 bit).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-high reset (1 = reset, sampled on clk rising edge). The name is codebase legacy; polarity is high.
- accel_state  out  acc_state_t (2 bit)  encoding: IDLE=0, RUN=1, WRITE=2, DONE=3.
- accel_error  out  acc_error_t (2 bit)  encoding: NO_ERR=0, ADDR_RANGE=1, BUSY_ACCESS=2.
- start  in  1  start request; rising edge triggers.
- done  out  1  one-cycle completion pulse.
- output_length_byte  out  6  number of valid result bytes.
- mem_en  in  1  host access enable.
- mem_addr  in  MEM_ADDR_WIDTH  word address.
- mem_we  in  1  1 = write, 0 = read.
- mem_be  in  MEM_DATA_WIDTH/8  byte enables; bit k covers bits 8k+7:8k.
- mem_wdata  in  MEM_DATA_WIDTH  write data.
- mem_rdata  out  MEM_DATA_WIDTH  read data.
- acc_state_t and acc_error_t are declared in the shared accelerator package.

Behaviour:
- Reset: state IDLE, all memory words 0, accel_error NO_ERR, done 0, output_length_byte 0, mem_rdata 0, start-edge register 0. Reset mid-operation aborts immediately with the same values.
- Host write (IDLE or DONE, mem_en=1, mem_we=1, mem_addr < MEM_DEPTH): bytes with mem_be[k]=1 are updated at the clock edge; other bytes are kept.
- Host read (IDLE or DONE, mem_en=1, mem_we=0, addr in range): mem_rdata = mem[addr] one cycle later (registered). mem_rdata holds its value when there is no read.
- Out of range (mem_en=1, mem_addr >= MEM_DEPTH): write is dropped; read returns 0 next cycle; accel_error <= ADDR_RANGE.
- Host access in RUN or WRITE: ignored; reads return 0; accel_error <= BUSY_ACCESS.
- accel_error is sticky. Only reset or an accepted start clears it. The latest error overwrites the earlier one. It does not block operation.
- Start detection: start_q registers start; the trigger is start & ~start_q. The trigger is accepted only in IDLE or DONE, and ignored in RUN/WRITE. A level held high does not retrigger.
- Write and start in the same cycle: the write is committed first, so processing sees the new data.
- IDLE/DONE -> RUN on an accepted trigger: index <= 0, sum <= 0, xor <= 0, accel_error <= NO_ERR, output_length_byte <= 0.
- RUN: each cycle reads mem[index] and sets sum += word (mod 2^32) and xor ^= word. It lasts exactly MEM_DEPTH cycles, index 0..MEM_DEPTH-1, then -> WRITE.
- WRITE: one cycle. mem[0] <= sum, mem[1] <= xor, output_length_byte <= 8, then -> DONE.
- DONE: done = 1 for exactly this first DONE cycle and 0 afterwards. The state stays DONE (host may read and write) until the next trigger; it returns to IDLE only via reset.
- Latency: trigger sampled at edge T gives done = 1 during cycle T+MEM_DEPTH+2 (T+18 at default).
- Results persist in memory until overwritten by the host or a new run.

Test Plan:
- Reset, then read addr 0..15 -> all 0x00000000; accel_state IDLE; done 0; output_length_byte 0; accel_error NO_ERR.
- Write word0=0x55555555, word1=0x80000000, words 2..15=0, word41=0x00000001 (addr 16..42 written as 0 or 1) -> accel_error ADDR_RANGE. Then raise start and hold it high:
  - state RUN for 16 cycles, WRITE, DONE;
  - done pulses once, 18 cycles after the trigger edge; no retrigger;
  - accel_error cleared to NO_ERR at start;
  - readback word0=0xD5555555, word1=0xD5555555, word2..15 = 0; output_length_byte = 8.
- Byte enable: write 0xFFFFFFFF to addr 3, then 0x00000000 with mem_be=4'b0101 -> read 0xFF00FF00.
- Host read of addr 2 during RUN -> rdata 0 and accel_error BUSY_ACCESS. A start edge during RUN is ignored and done pulses exactly once.
- Memory all 0xFFFFFFFF, run -> word0=0xFFFFFFF0 (sum wraps), word1=0x00000000.
- Assert rst_n=1 for one cycle mid-RUN -> next cycle IDLE, memory cleared, no done pulse.
